// File: rtl/process_scheduler.sv
// process_scheduler
//   Round-robin context-switch controller for NPROC process slots. Each slot
//   holds a 2-bit state (FREE/READY/RUNNING/BLOCKED), a saved PC and a memory
//   base address. A controller FSM (IDLE, RUN, SAVE, SCAN, LOAD) saves the
//   running process on an event, scans forward for the next READY slot and
//   loads it.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   create, create_pc,
//   create_base             register a new process in the lowest FREE slot
//   quantum, halt, block    events for the running process (sampled in RUN)
//   wake, wake_pid          I/O of process wake_pid completed
//   cur_pc                  PC of the running process, saved on switch-out
//   running                 a process is executing (FSM in RUN)
//   ctx_switch              one-cycle pulse while the FSM is in LOAD
//   pid, load_pc, base_addr selected process; held from LOAD to next LOAD
//   full                    no slot is FREE
//   fsm_state               controller state (IDLE=0 RUN=1 SAVE=2 SCAN=3 LOAD=4)
//
// Handshake: there is no backpressure. create/wake/events are single-cycle
// requests taken on the rising edge they are high; create is dropped while
// full=1 and events are dropped outside RUN.

module process_scheduler #(
    parameter int NPROC      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int PID_W      = $clog2(NPROC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  create,
    input  logic [DATA_WIDTH-1:0] create_pc,
    input  logic [DATA_WIDTH-1:0] create_base,
    input  logic                  quantum,
    input  logic                  halt,
    input  logic                  block,
    input  logic                  wake,
    input  logic [PID_W-1:0]      wake_pid,
    input  logic [DATA_WIDTH-1:0] cur_pc,
    output logic                  running,
    output logic                  ctx_switch,
    output logic [PID_W-1:0]      pid,
    output logic [DATA_WIDTH-1:0] load_pc,
    output logic [DATA_WIDTH-1:0] base_addr,
    output logic                  full,
    output logic [2:0]            fsm_state
);

    typedef enum logic [2:0] {IDLE, RUN, SAVE, SCAN, LOAD} fsm_t;
    typedef enum logic [1:0] {SLOT_FREE, SLOT_READY, SLOT_RUNNING, SLOT_BLOCKED} slot_t;

    localparam logic [1:0] EV_QUANTUM = 2'd0;
    localparam logic [1:0] EV_BLOCK   = 2'd1;
    localparam logic [1:0] EV_HALT    = 2'd2;

    fsm_t                  state_q, state_d;
    logic [PID_W-1:0]      scan_ptr_q, scan_ptr_d;
    logic [PID_W-1:0]      scan_cnt_q, scan_cnt_d;
    logic [1:0]            ev_q, ev_d;
    slot_t                 slot_st_q   [NPROC];
    slot_t                 slot_st_d   [NPROC];
    logic [DATA_WIDTH-1:0] slot_pc_q   [NPROC];
    logic [DATA_WIDTH-1:0] slot_pc_d   [NPROC];
    logic [DATA_WIDTH-1:0] slot_base_q [NPROC];
    logic [DATA_WIDTH-1:0] slot_base_d [NPROC];

    logic                  any_ready;
    logic                  free_found;
    logic [PID_W-1:0]      free_idx;
    logic                  load_sel;
    logic                  full_d;

    assign fsm_state = state_q;

    always_comb begin
        state_d     = state_q;
        scan_ptr_d  = scan_ptr_q;
        scan_cnt_d  = scan_cnt_q;
        ev_d        = ev_q;
        slot_st_d   = slot_st_q;
        slot_pc_d   = slot_pc_q;
        slot_base_d = slot_base_q;
        load_sel    = 1'b0;
        any_ready   = 1'b0;
        free_found  = 1'b0;
        free_idx    = '0;
        full_d      = 1'b1;

        // All decisions use the pre-edge slot states.
        for (int i = 0; i < NPROC; i++) begin
            if (slot_st_q[i] == SLOT_READY) begin
                any_ready = 1'b1;
            end
            if (!free_found && slot_st_q[i] == SLOT_FREE) begin
                free_found = 1'b1;
                free_idx   = PID_W'(i);
            end
        end

        // free_found is exactly !full, so a create while full drops out here.
        if (create && free_found) begin
            slot_st_d[free_idx]   = SLOT_READY;
            slot_pc_d[free_idx]   = create_pc;
            slot_base_d[free_idx] = create_base;
        end

        if (wake && slot_st_q[wake_pid] == SLOT_BLOCKED) begin
            slot_st_d[wake_pid] = SLOT_READY;
        end

        case (state_q)
            IDLE: begin
                if (any_ready) begin
                    state_d    = SCAN;
                    scan_ptr_d = pid + PID_W'(1);
                    scan_cnt_d = '0;
                end
            end
            RUN: begin
                if (halt) begin
                    ev_d    = EV_HALT;
                    state_d = SAVE;
                end else if (block) begin
                    ev_d    = EV_BLOCK;
                    state_d = SAVE;
                end else if (quantum) begin
                    ev_d    = EV_QUANTUM;
                    state_d = SAVE;
                end
            end
            SAVE: begin
                slot_pc_d[pid] = cur_pc;
                case (ev_q)
                    EV_HALT:  slot_st_d[pid] = SLOT_FREE;
                    // A wake arriving in the same cycle as the block save wins,
                    // otherwise the completion would be lost.
                    EV_BLOCK: slot_st_d[pid] = (wake && wake_pid == pid) ? SLOT_READY
                                                                          : SLOT_BLOCKED;
                    default:  slot_st_d[pid] = SLOT_READY;
                endcase
                // Starting after pid makes a preempted process the last candidate.
                scan_ptr_d = pid + PID_W'(1);
                scan_cnt_d = '0;
                state_d    = SCAN;
            end
            SCAN: begin
                if (slot_st_q[scan_ptr_q] == SLOT_READY) begin
                    // Selection is committed on the edge into LOAD so the
                    // registered outputs are valid while ctx_switch is high.
                    slot_st_d[scan_ptr_q] = SLOT_RUNNING;
                    load_sel              = 1'b1;
                    state_d               = LOAD;
                end else if (scan_cnt_q == PID_W'(NPROC - 1)) begin
                    state_d = IDLE;
                end else begin
                    scan_ptr_d = scan_ptr_q + PID_W'(1);
                    scan_cnt_d = scan_cnt_q + PID_W'(1);
                end
            end
            LOAD: begin
                state_d = RUN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        for (int i = 0; i < NPROC; i++) begin
            if (slot_st_d[i] == SLOT_FREE) begin
                full_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            scan_ptr_q <= '0;
            scan_cnt_q <= '0;
            ev_q       <= EV_QUANTUM;
            for (int i = 0; i < NPROC; i++) begin
                slot_st_q[i]   <= SLOT_FREE;
                slot_pc_q[i]   <= '0;
                slot_base_q[i] <= '0;
            end
            running    <= 1'b0;
            ctx_switch <= 1'b0;
            pid        <= '0;
            load_pc    <= '0;
            base_addr  <= '0;
            full       <= 1'b0;
        end else begin
            state_q     <= state_d;
            scan_ptr_q  <= scan_ptr_d;
            scan_cnt_q  <= scan_cnt_d;
            ev_q        <= ev_d;
            slot_st_q   <= slot_st_d;
            slot_pc_q   <= slot_pc_d;
            slot_base_q <= slot_base_d;
            running     <= (state_d == RUN);
            ctx_switch  <= (state_d == LOAD);
            full        <= full_d;
            if (load_sel) begin
                pid       <= scan_ptr_q;
                load_pc   <= slot_pc_q[scan_ptr_q];
                base_addr <= slot_base_q[scan_ptr_q];
            end
        end
    end

endmodule

// File: tb/tb_process_scheduler.sv
// Testbench for process_scheduler (NPROC=4, DATA_WIDTH=32).
// Every expected context switch {pid, load_pc, base_addr} is pushed to exp_q
// when the stimulus that causes it is driven; a negedge monitor pops and
// compares on each ctx_switch. Direct checks cover reset values, latency,
// full, idle and reset-during-scan behaviour.

module tb_process_scheduler;

  localparam int NPROC = 4;
  localparam int DW    = 32;
  localparam int PW    = 2;
  localparam int EW    = PW + 2 * DW;

  localparam logic [63:0] ST_IDLE = 64'd0;
  localparam logic [63:0] ST_SAVE = 64'd2;

  logic          clk;
  logic          reset;
  logic          create;
  logic [DW-1:0] create_pc;
  logic [DW-1:0] create_base;
  logic          quantum;
  logic          halt;
  logic          block;
  logic          wake;
  logic [PW-1:0] wake_pid;
  logic [DW-1:0] cur_pc;
  logic          running;
  logic          ctx_switch;
  logic [PW-1:0] pid;
  logic [DW-1:0] load_pc;
  logic [DW-1:0] base_addr;
  logic          full;
  logic [2:0]    fsm_state;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  process_scheduler #(.NPROC(NPROC), .DATA_WIDTH(DW), .PID_W(PW)) dut (
    .clk         (clk),
    .reset       (reset),
    .create      (create),
    .create_pc   (create_pc),
    .create_base (create_base),
    .quantum     (quantum),
    .halt        (halt),
    .block       (block),
    .wake        (wake),
    .wake_pid    (wake_pid),
    .cur_pc      (cur_pc),
    .running     (running),
    .ctx_switch  (ctx_switch),
    .pid         (pid),
    .load_pc     (load_pc),
    .base_addr   (base_addr),
    .full        (full),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!reset && ctx_switch) begin
      if (exp_q.size() == 0) begin
        check("ctx_unexpected", 64'(ctx_switch), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("ctx_pid",       64'(pid),       64'(e[EW-1 -: PW]));
        check("ctx_load_pc",   64'(load_pc),   64'(e[2*DW-1 -: DW]));
        check("ctx_base_addr", 64'(base_addr), 64'(e[DW-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ctx(input logic [PW-1:0] p, input logic [DW-1:0] pc, input logic [DW-1:0] base);
    exp_q.push_back({p, pc, base});
  endtask

  task automatic do_create(input logic [DW-1:0] pc, input logic [DW-1:0] base);
    create      = 1'b1;
    create_pc   = pc;
    create_base = base;
    tick(1);
    create      = 1'b0;
  endtask

  // Leaves the bench in the LOAD cycle (ctx_switch high) or reports a timeout.
  task automatic wait_ctx(input int budget);
    int k = 0;
    while (!ctx_switch && k < budget) begin
      tick(1);
      k++;
    end
    if (!ctx_switch) check("ctx_timeout", 64'(ctx_switch), 64'd1);
  endtask

  // kind: 0 quantum, 1 block, 2 halt, 3 halt+quantum. Ends in the RUN cycle.
  task automatic run_event(input int kind, input logic [DW-1:0] pc_now,
                           input logic [PW-1:0] e_pid, input logic [DW-1:0] e_pc,
                           input logic [DW-1:0] e_base);
    cur_pc = pc_now;
    expect_ctx(e_pid, e_pc, e_base);
    quantum = (kind == 0 || kind == 3);
    block   = (kind == 1);
    halt    = (kind == 2 || kind == 3);
    tick(1);
    quantum = 1'b0;
    block   = 1'b0;
    halt    = 1'b0;
    wait_ctx(40);
    tick(1);
    check("running_after_load", 64'(running), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; create = 1'b0; create_pc = '0; create_base = '0;
    quantum = 1'b0; halt = 1'b0; block = 1'b0; wake = 1'b0; wake_pid = '0; cur_pc = '0;
    tick(2);
    reset = 1'b0;

    // reset values
    check("rst_running",    64'(running),    64'd0);
    check("rst_ctx_switch", 64'(ctx_switch), 64'd0);
    check("rst_pid",        64'(pid),        64'd0);
    check("rst_load_pc",    64'(load_pc),    64'd0);
    check("rst_base_addr",  64'(base_addr),  64'd0);
    check("rst_full",       64'(full),       64'd0);
    check("rst_state",      64'(fsm_state),  ST_IDLE);

    // first process dispatched from IDLE
    expect_ctx(2'd0, 32'h40, 32'h100);
    do_create(32'h40, 32'h100);
    wait_ctx(30);
    tick(1);
    check("first_running", 64'(running),    64'd1);
    check("first_ctx_one", 64'(ctx_switch), 64'd0);

    // second process, then quantum with latency checks
    do_create(32'h200, 32'h300);
    cur_pc  = 32'h48;
    expect_ctx(2'd1, 32'h200, 32'h300);
    quantum = 1'b1;
    tick(1);                       // t+1: SAVE
    quantum = 1'b0;
    check("lat_save_state",   64'(fsm_state), ST_SAVE);
    check("lat_save_running", 64'(running),   64'd0);
    tick(1);                       // t+2: SCAN
    check("lat_t2_ctx", 64'(ctx_switch), 64'd0);
    tick(1);                       // t+3: LOAD
    check("lat_t3_ctx", 64'(ctx_switch), 64'd1);
    check("lat_t3_pid", 64'(pid),        64'd1);
    tick(1);                       // t+4: RUN
    check("lat_t4_running", 64'(running), 64'd1);

    // preempted process 0 comes back with its saved PC
    run_event(0, 32'h210, 2'd0, 32'h48, 32'h100);

    // fill the table; fifth create is ignored
    do_create(32'h400, 32'h500);
    do_create(32'h600, 32'h700);
    check("full_after_4", 64'(full), 64'd1);
    do_create(32'h800, 32'h900);
    check("full_after_5", 64'(full), 64'd1);

    run_event(0, 32'h50,  2'd1, 32'h210, 32'h300);
    run_event(0, 32'h220, 2'd2, 32'h400, 32'h500);
    run_event(2, 32'h410, 2'd3, 32'h600, 32'h700);   // halt pid 2
    check("full_after_halt", 64'(full), 64'd0);
    run_event(0, 32'h610, 2'd0, 32'h50,  32'h100);
    run_event(3, 32'h58,  2'd1, 32'h220, 32'h300);   // halt beats quantum on pid 0
    run_event(2, 32'h230, 2'd3, 32'h610, 32'h700);   // halt pid 1, only pid 3 left

    // only process blocks -> IDLE
    cur_pc = 32'h620;
    block  = 1'b1;
    tick(1);
    block  = 1'b0;
    tick(8);
    check("idle_running", 64'(running),   64'd0);
    check("idle_state",   64'(fsm_state), ST_IDLE);

    // wake resumes it; an event during LOAD is ignored
    expect_ctx(2'd3, 32'h620, 32'h700);
    wake_pid = 2'd3;
    wake     = 1'b1;
    tick(1);
    wake     = 1'b0;
    wait_ctx(30);
    quantum = 1'b1;
    tick(1);
    quantum = 1'b0;
    check("load_evt_running", 64'(running), 64'd1);
    tick(4);
    check("load_evt_pid",     64'(pid),     64'd3);
    check("load_evt_run2",    64'(running), 64'd1);

    // block and wake of the same pid in the SAVE cycle -> READY
    cur_pc = 32'h630;
    expect_ctx(2'd3, 32'h630, 32'h700);
    block  = 1'b1;
    tick(1);
    block    = 1'b0;
    wake_pid = 2'd3;
    wake     = 1'b1;
    tick(1);
    wake     = 1'b0;
    wait_ctx(30);
    tick(1);
    check("blk_wake_running", 64'(running), 64'd1);

    // reset during SCAN with create=1
    do_create(32'h1000, 32'h2000);
    cur_pc  = 32'h640;
    quantum = 1'b1;
    tick(1);
    quantum = 1'b0;
    tick(1);                       // SCAN cycle
    reset       = 1'b1;
    create      = 1'b1;
    create_pc   = 32'h3000;
    create_base = 32'h4000;
    tick(1);
    check("scanrst_running", 64'(running),    64'd0);
    check("scanrst_ctx",     64'(ctx_switch), 64'd0);
    check("scanrst_pid",     64'(pid),        64'd0);
    check("scanrst_load_pc", 64'(load_pc),    64'd0);
    check("scanrst_base",    64'(base_addr),  64'd0);
    check("scanrst_full",    64'(full),       64'd0);
    check("scanrst_state",   64'(fsm_state),  ST_IDLE);
    reset  = 1'b0;
    create = 1'b0;
    tick(12);
    check("postrst_running", 64'(running),   64'd0);
    check("postrst_state",   64'(fsm_state), ST_IDLE);

    // new process after reset lands in slot 0
    expect_ctx(2'd0, 32'h44, 32'h144);
    do_create(32'h44, 32'h144);
    wait_ctx(30);
    tick(1);
    check("postrst_run", 64'(running), 64'd1);

    tick(2);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
